alu_operand_sel: RTL and testbench
==================================

Name: alu_operand_sel

Overview:
Parametrised operand selector for ALU input B. It generalises the rs2/immediate choice to NSRC sources, for example rs2, immediate, EX/MEM forward and MEM/WB forward. It adds an optional one-entry pipeline register with a valid/ready handshake, a synchronous flush and a sticky out-of-range select error flag. It sits between decode/forwarding logic and the ALU of the pipelined core.

Parameters:
XLEN, 32, operand width in bits
NSRC, 4, number of candidate sources (>=2)
PIPE, 1, 1 = registered output stage with handshake; 0 = combinational pass-through
SEL_W, max(1,$clog2(NSRC)), select width (derived, not overridden)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush (branch/trap)
in_valid  in  1  upstream operand request valid
in_ready  out  1  stage can accept request
src_sel  in  SEL_W  source index; 0 = rs2, 1 = imm by convention
src_data  in  NSRC*XLEN  packed sources; source i at [i*XLEN +: XLEN]
out_valid  out  1  alu_b holds a valid operand
out_ready  in  1  ALU/EX consumes operand
alu_b  out  XLEN  selected operand
sel_err  out  1  sticky: an out-of-range src_sel was accepted
err_clr  in  1  synchronous clear of sel_err

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, alu_b=0, sel_err=0. Applies immediately regardless of handshake state; an in-flight operand is discarded.
- Selection: sel_data = src_data[src_sel*XLEN +: XLEN] when src_sel < NSRC.
  - When src_sel >= NSRC (possible only when NSRC is not a power of 2), sel_data = 0.
- Accept: acc = in_valid & in_ready.
- PIPE=1:
  - in_ready = ~out_valid | out_ready. This gives full throughput with no bubble when out_ready=1.
  - On the clock edge, in priority order:
    - flush=1: out_valid<=0. alu_b holds its value; the accept is ignored.
    - acc=1: out_valid<=1, alu_b<=sel_data. Latency is 1 cycle.
    - out_valid & out_ready: out_valid<=0, alu_b holds.
    - otherwise hold.
  - Stall (out_valid=1, out_ready=0): alu_b and out_valid are stable. in_ready=0. src_* are ignored.
  - Simultaneous consume and accept in the same cycle: new data is loaded and out_valid stays 1.
- PIPE=0:
  - alu_b = sel_data, out_valid = in_valid & ~flush, in_ready = out_ready.
  - No state except sel_err.
- sel_err:
  - Set on an edge where acc=1, flush=0 and src_sel >= NSRC.
  - Cleared by err_clr on the edge.
  - If set and clear occur on the same edge, set wins.
  - Reset clears it.
- No X propagation: a stable src_sel and src_data while in_valid=0 must not change any output in PIPE=1.
- All registers use the rising edge of clk; rst_n is the only asynchronous input.

Test Plan:
- Reset/basic, PIPE=1, NSRC=4: assert rst_n=0 mid-stall with out_valid=1 -> out_valid=0, alu_b=0, sel_err=0 immediately. Release reset, then send src_sel=1 with imm=0x0000_0FFC -> next cycle out_valid=1, alu_b=0x0000_0FFC.
- Back-to-back: out_ready=1, 4 accepts with sel 0,1,2,3 and sources 0x11,0x22,0x33,0x44 -> alu_b = 0x11,0x22,0x33,0x44 on consecutive cycles, in_ready constantly 1.
- Stall: hold out_ready=0 for 3 cycles after loading 0xDEAD_BEEF while in_valid=1 with new data -> in_ready=0, alu_b stays 0xDEAD_BEEF. Raise out_ready -> new value loads on the same edge.
- Flush priority: flush=1 on the same edge as acc with sel=2 -> out_valid=0 next cycle and the previous alu_b is retained. On the following cycle with flush=0 the accept succeeds.
- Out-of-range, NSRC=3, SEL_W=2: accept with src_sel=3 -> alu_b=0, sel_err=1 stays set. Then err_clr=1 together with another sel=3 accept -> sel_err remains 1. Then err_clr alone -> sel_err=0.
- PIPE=0, XLEN=64: sel=0 with rs2=0x8000_0000_0000_0001 -> alu_b equals it in the same cycle. in_ready follows out_ready. flush=1 forces out_valid=0 combinationally.

Source files
------------

// File: rtl/alu_operand_sel.sv
// Operand selector for ALU input B: picks one of NSRC packed sources, with an
// optional one-entry valid/ready output register, flush and a sticky select error.
module alu_operand_sel #(
  parameter int XLEN = 32,
  parameter int NSRC = 4,
  parameter int PIPE = 1,
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     src_sel,
  input  logic [NSRC*XLEN-1:0] src_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      alu_b,
  output logic                 sel_err,
  input  logic                 err_clr
);

  logic [XLEN-1:0] sel_data_s;
  logic            in_range_s;
  logic            in_ready_s;
  logic            acc_s;
  logic            sel_err_r;

  // Out-of-range indices only exist when NSRC is not a power of two.
  assign in_range_s = (32'(src_sel) < 32'(NSRC));

  // Source multiplexer; out-of-range selects yield zero.
  always_comb begin
    sel_data_s = {XLEN{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      if (src_sel == SEL_W'(i)) begin
        sel_data_s = src_data[i*XLEN +: XLEN];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  assign acc_s    = in_valid & in_ready_s;
  assign in_ready = in_ready_s;

  // Sticky select-error flag; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_r <= 1'b0;
    end else if (acc_s && !flush && !in_range_s) begin
      sel_err_r <= 1'b1;
    end else if (err_clr) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= sel_err_r;
    end
  end

  assign sel_err = sel_err_r;

  if (PIPE != 0) begin : g_pipe
    logic            out_valid_r;
    logic [XLEN-1:0] alu_b_r;

    // A consumed slot can be refilled on the same edge, so no bubble at full rate.
    assign in_ready_s = ~out_valid_r | out_ready;

    // Output stage: flush beats accept, accept beats consume.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid_r <= 1'b0;
        alu_b_r     <= {XLEN{1'b0}};
      end else if (flush) begin
        out_valid_r <= 1'b0;
        alu_b_r     <= alu_b_r;
      end else if (acc_s) begin
        out_valid_r <= 1'b1;
        alu_b_r     <= sel_data_s;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
        alu_b_r     <= alu_b_r;
      end else begin
        out_valid_r <= out_valid_r;
        alu_b_r     <= alu_b_r;
      end
    end

    assign out_valid = out_valid_r;
    assign alu_b     = alu_b_r;
  end else begin : g_comb
    assign in_ready_s = out_ready;
    assign out_valid  = in_valid & ~flush;
    assign alu_b      = sel_data_s;
  end

endmodule

// File: tb/tb_alu_operand_sel.sv
// Directed self-checking bench for alu_operand_sel: registered 4-source,
// registered 3-source (out-of-range select) and 64-bit pass-through variants.
module tb_alu_operand_sel;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // DUT a: PIPE=1, NSRC=4, XLEN=32
  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic          a_sel_err, a_err_clr;
  logic [1:0]    a_src_sel;
  logic [127:0]  a_src_data;
  logic [31:0]   a_alu_b;

  // DUT b: PIPE=1, NSRC=3, XLEN=32
  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic          b_sel_err, b_err_clr;
  logic [1:0]    b_src_sel;
  logic [95:0]   b_src_data;
  logic [31:0]   b_alu_b;

  // DUT c: PIPE=0, NSRC=4, XLEN=64
  logic          c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic          c_sel_err, c_err_clr;
  logic [1:0]    c_src_sel;
  logic [255:0]  c_src_data;
  logic [63:0]   c_alu_b;

  alu_operand_sel #(.XLEN(32), .NSRC(4), .PIPE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .src_sel(a_src_sel), .src_data(a_src_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .alu_b(a_alu_b),
    .sel_err(a_sel_err), .err_clr(a_err_clr));

  alu_operand_sel #(.XLEN(32), .NSRC(3), .PIPE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .src_sel(b_src_sel), .src_data(b_src_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .alu_b(b_alu_b),
    .sel_err(b_sel_err), .err_clr(b_err_clr));

  alu_operand_sel #(.XLEN(64), .NSRC(4), .PIPE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .src_sel(c_src_sel), .src_data(c_src_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .alu_b(c_alu_b),
    .sel_err(c_sel_err), .err_clr(c_err_clr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_in_valid = 1'b1; a_src_sel = 2'd2; a_out_ready = 1'b0;
    a_src_data = {32'h0, 32'hAAAA_5555, 32'h0, 32'h0};
    tick();
    checks++;
    if (a_out_valid !== 1'b1 || a_alu_b !== 32'hAAAA_5555) begin
      failures++;
      $display("FAIL preload: out_valid=%b alu_b=%h, want 1 aaaa5555", a_out_valid, a_alu_b);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_alu_b !== 32'h0 || a_sel_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: out_valid=%b alu_b=%h sel_err=%b, want 0 0 0",
               a_out_valid, a_alu_b, a_sel_err);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_alu_b !== 32'h0 || b_sel_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_b: out_valid=%b alu_b=%h sel_err=%b, want 0 0 0",
               b_out_valid, b_alu_b, b_sel_err);
    end
    #1;
    rst_n = 1'b1;
    a_src_sel = 2'd1; a_out_ready = 1'b1;
    a_src_data = {32'h0, 32'h0, 32'h0000_0FFC, 32'h0};
    tick();
    checks++;
    if (a_out_valid !== 1'b1 || a_alu_b !== 32'h0000_0FFC) begin
      failures++;
      $display("FAIL first_accept: out_valid=%b alu_b=%h, want 1 00000ffc", a_out_valid, a_alu_b);
    end
    a_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33; exp_v[3] = 32'h44;
    a_src_data = {32'h44, 32'h33, 32'h22, 32'h11};
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_src_sel = 2'(i);
      #1;
      checks++;
      if (a_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, a_in_ready);
      end
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_alu_b !== exp_v[i]) begin
        failures++;
        $display("FAIL b2b_data[%0d]: out_valid=%b alu_b=%h, want 1 %h", i, a_out_valid, a_alu_b, exp_v[i]);
      end
    end
    a_in_valid = 1'b0;
    tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_alu_b !== 32'h44) begin
      failures++;
      $display("FAIL b2b_drain: out_valid=%b alu_b=%h, want 0 44", a_out_valid, a_alu_b);
    end
    a_src_data = {32'h9, 32'h8, 32'h7, 32'h6};
    a_src_sel = 2'd1;
    tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_alu_b !== 32'h44) begin
      failures++;
      $display("FAIL idle_stable: out_valid=%b alu_b=%h, want 0 44", a_out_valid, a_alu_b);
    end
  endtask

  task automatic test_stall();
    a_in_valid = 1'b1; a_src_sel = 2'd0; a_out_ready = 1'b0;
    a_src_data = {32'h0, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF};
    tick();
    a_src_sel = 2'd1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (a_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_in_ready[%0d]: got %b want 0", i, a_in_ready);
      end
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_alu_b !== 32'hDEAD_BEEF) begin
        failures++;
        $display("FAIL stall_hold[%0d]: out_valid=%b alu_b=%h, want 1 deadbeef", i, a_out_valid, a_alu_b);
      end
    end
    a_out_ready = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready: got %b want 1", a_in_ready);
    end
    tick();
    checks++;
    if (a_out_valid !== 1'b1 || a_alu_b !== 32'h1234_5678) begin
      failures++;
      $display("FAIL stall_release_load: out_valid=%b alu_b=%h, want 1 12345678", a_out_valid, a_alu_b);
    end
    a_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    a_in_valid = 1'b1; a_src_sel = 2'd2; a_out_ready = 1'b1; a_flush = 1'b1;
    a_src_data = {32'h0, 32'hCAFE_0002, 32'h0, 32'h0};
    tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_alu_b !== 32'h1234_5678) begin
      failures++;
      $display("FAIL flush_priority: out_valid=%b alu_b=%h, want 0 12345678", a_out_valid, a_alu_b);
    end
    a_flush = 1'b0;
    tick();
    checks++;
    if (a_out_valid !== 1'b1 || a_alu_b !== 32'hCAFE_0002) begin
      failures++;
      $display("FAIL flush_after: out_valid=%b alu_b=%h, want 1 cafe0002", a_out_valid, a_alu_b);
    end
    a_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    b_in_valid = 1'b1; b_src_sel = 2'd2; b_out_ready = 1'b1;
    b_src_data = {32'h55, 32'h66, 32'h77};
    tick();
    checks++;
    if (b_alu_b !== 32'h55 || b_sel_err !== 1'b0) begin
      failures++;
      $display("FAIL oor_inrange: alu_b=%h sel_err=%b, want 55 0", b_alu_b, b_sel_err);
    end
    b_src_sel = 2'd3;
    tick();
    checks++;
    if (b_out_valid !== 1'b1 || b_alu_b !== 32'h0 || b_sel_err !== 1'b1) begin
      failures++;
      $display("FAIL oor_accept: out_valid=%b alu_b=%h sel_err=%b, want 1 0 1", b_out_valid, b_alu_b, b_sel_err);
    end
    b_in_valid = 1'b0;
    tick();
    checks++;
    if (b_sel_err !== 1'b1) begin
      failures++;
      $display("FAIL oor_sticky: sel_err=%b want 1", b_sel_err);
    end
    b_in_valid = 1'b1; b_err_clr = 1'b1;
    tick();
    checks++;
    if (b_sel_err !== 1'b1) begin
      failures++;
      $display("FAIL oor_set_wins: sel_err=%b want 1", b_sel_err);
    end
    b_in_valid = 1'b0;
    tick();
    checks++;
    if (b_sel_err !== 1'b0) begin
      failures++;
      $display("FAIL oor_clear: sel_err=%b want 0", b_sel_err);
    end
    b_err_clr = 1'b0; b_in_valid = 1'b1; b_flush = 1'b1;
    tick();
    checks++;
    if (b_sel_err !== 1'b0 || b_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL oor_flushed: sel_err=%b out_valid=%b want 0 0", b_sel_err, b_out_valid);
    end
    b_in_valid = 1'b0; b_flush = 1'b0;
  endtask

  task automatic test_passthrough();
    c_in_valid = 1'b1; c_src_sel = 2'd0; c_out_ready = 1'b1; c_flush = 1'b0;
    c_src_data = {64'h4, 64'h3, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0001};
    #1;
    checks++;
    if (c_alu_b !== 64'h8000_0000_0000_0001 || c_out_valid !== 1'b1 || c_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL pt_select: alu_b=%h out_valid=%b in_ready=%b, want 8000000000000001 1 1",
               c_alu_b, c_out_valid, c_in_ready);
    end
    c_out_ready = 1'b0;
    #1;
    checks++;
    if (c_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL pt_in_ready: got %b want 0", c_in_ready);
    end
    c_flush = 1'b1;
    #1;
    checks++;
    if (c_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL pt_flush: out_valid=%b want 0", c_out_valid);
    end
    c_flush = 1'b0; c_src_sel = 2'd1;
    #1;
    checks++;
    if (c_alu_b !== 64'h0123_4567_89AB_CDEF || c_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL pt_sel1: alu_b=%h out_valid=%b, want 0123456789abcdef 1", c_alu_b, c_out_valid);
    end
  endtask

  initial begin
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_err_clr = 1'b0;
    a_src_sel = 2'd0; a_src_data = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_err_clr = 1'b0;
    b_src_sel = 2'd0; b_src_data = '0;
    c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_err_clr = 1'b0;
    c_src_sel = 2'd0; c_src_data = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_out_of_range();
    test_passthrough();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
